// File: rtl/tone_decoder.sv
// Buzzer tone decoder: measures the fall-to-fall period of pwm_in and locks a 4-bit note code.
// Optional low-pulse width measurement is built when TONE_DUTY_MEAS_EN is defined.
module tone_decoder #(
   parameter int CLK_PRE   = 50_000_000,
   parameter int TOL_SHIFT = 6,
   parameter int CONFIRM   = 2,
   parameter int TIMEOUT   = 500_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pwm_in,
   output logic [3:0]  note_code,
   output logic        note_valid,
   output logic        locked,
   output logic [19:0] period,
   output logic [19:0] low_width
);

   typedef enum logic [1:0] {S_SILENT, S_ARMED, S_TRACK, S_LOCKED} state_t;

   localparam logic [19:0] CNT_MAX = 20'hF_FFFF;
   localparam logic [19:0] TO_CNT  = 20'(TIMEOUT);
   localparam logic [3:0]  CONF    = 4'(CONFIRM);

   function automatic int note_freq(input logic [3:0] k);
      case (k)
         4'd1:    return 32'd262;
         4'd2:    return 32'd294;
         4'd3:    return 32'd330;
         4'd4:    return 32'd349;
         4'd5:    return 32'd392;
         4'd6:    return 32'd440;
         4'd7:    return 32'd494;
         4'd8:    return 32'd523;
         4'd9:    return 32'd587;
         4'd10:   return 32'd659;
         4'd11:   return 32'd698;
         4'd12:   return 32'd784;
         4'd13:   return 32'd880;
         4'd14:   return 32'd988;
         default: return 32'd1;
      endcase
   endfunction

   function automatic logic [19:0] note_period(input logic [3:0] k);
      return 20'(CLK_PRE / note_freq(k));
   endfunction

   // |meas - p_k| <= p_k >> TOL_SHIFT in 21-bit signed arithmetic; a saturated count never matches
   function automatic logic tone_match(input logic [19:0] meas, input logic [19:0] p_k);
      logic signed [20:0] diff;
      logic signed [20:0] tol;
      diff = $signed({1'b0, meas}) - $signed({1'b0, p_k});
      if (diff < 21'sd0) diff = -diff;
      else               diff = diff;
      tol = $signed({1'b0, p_k >> TOL_SHIFT});
      return (meas != CNT_MAX) && (diff <= tol);
   endfunction

   logic        r_sync1, r_sync2, r_sync3, r_fe;
   logic [19:0] r_cnt, r_period;
   state_t      r_state;
   logic [3:0]  r_cand, r_note_code, r_prev_code;
   logic [2:0]  r_mcnt;
   logic        r_locked, r_note_valid;
   logic [3:0]  w_code;
   logic        w_timeout;

   // Synchronizer, registered falling-edge detect, and the shared period/timeout counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_sync3  <= 1'b1;
         r_fe     <= 1'b0;
         r_cnt    <= 20'd0;
         r_period <= 20'd0;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_fe    <= r_sync3 & ~r_sync2;
         if (r_fe) begin
            r_cnt    <= 20'd1;
            r_period <= r_cnt;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 20'd1;
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

   // Lowest matching note code for the period ending in this cycle
   always_comb begin
      w_code = 4'd0;
      for (int k = 14; k >= 1; k--) begin
         if (tone_match(r_cnt, note_period(4'(k)))) w_code = 4'(k);
         else                                       w_code = w_code;
      end
   end

   assign w_timeout = (r_cnt == TO_CNT) && !r_fe;

   // Lock FSM; note_valid follows any change of note_code by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_SILENT;
         r_cand       <= 4'd0;
         r_mcnt       <= 3'd0;
         r_note_code  <= 4'd0;
         r_prev_code  <= 4'd0;
         r_locked     <= 1'b0;
         r_note_valid <= 1'b0;
      end else begin
         r_prev_code  <= r_note_code;
         r_note_valid <= (r_note_code != r_prev_code);
         case (r_state)
            S_SILENT: begin
               if (r_fe) r_state <= S_ARMED;
               else      r_state <= S_SILENT;
            end
            S_ARMED, S_TRACK, S_LOCKED: begin
               if (r_fe) begin
                  if (w_code == 4'd0) begin
                     r_state <= S_ARMED;
                     r_cand  <= 4'd0;
                     r_mcnt  <= 3'd0;
                  end else if ((r_state == S_TRACK) && (w_code == r_cand)) begin
                     if (({1'b0, r_mcnt} + 4'd1) >= CONF) begin
                        r_state     <= S_LOCKED;
                        r_note_code <= r_cand;
                        r_locked    <= 1'b1;
                     end else begin
                        r_state <= S_TRACK;
                     end
                     r_mcnt <= r_mcnt + 3'd1;
                  end else if ((r_state == S_LOCKED) && (w_code == r_note_code)) begin
                     r_state <= S_LOCKED;
                  end else begin
                     r_cand <= w_code;
                     r_mcnt <= 3'd1;
                     if (CONF == 4'd1) begin
                        r_state     <= S_LOCKED;
                        r_note_code <= w_code;
                        r_locked    <= 1'b1;
                     end else begin
                        r_state <= S_TRACK;
                     end
                  end
               end else if (w_timeout) begin
                  r_state     <= S_SILENT;
                  r_cand      <= 4'd0;
                  r_mcnt      <= 3'd0;
                  r_note_code <= 4'd0;
                  r_locked    <= 1'b0;
               end else begin
                  r_state <= r_state;
               end
            end
            default: r_state <= S_SILENT;
         endcase
      end
   end

`ifdef TONE_DUTY_MEAS_EN
   logic [19:0] r_low_cnt, r_low_width;

   // Low-pulse width; fe fires after two low samples already passed, hence the preload of 2
   always_ff @(posedge clk) begin
      if (rst) begin
         r_low_cnt   <= 20'd0;
         r_low_width <= 20'd0;
      end else begin
         if (r_fe)                                r_low_cnt <= 20'd2;
         else if (!r_sync2 && r_low_cnt != CNT_MAX) r_low_cnt <= r_low_cnt + 20'd1;
         else                                     r_low_cnt <= r_low_cnt;
         if (r_sync2 && !r_sync3) r_low_width <= r_low_cnt;
         else                     r_low_width <= r_low_width;
      end
   end

   assign low_width = r_low_width;
`else
   assign low_width = 20'd0;
`endif

   assign note_code  = r_note_code;
   assign note_valid = r_note_valid;
   assign locked     = r_locked;
   assign period     = r_period;

endmodule

// File: tb/tb_tone_decoder.sv
// Randomized self-checking bench for tone_decoder against a fall-to-fall period model.
module tb_tone_decoder;

   localparam int CLK_PRE   = 250_000;
   localparam int TOL_SHIFT = 6;
   localparam int CONFIRM   = 2;
   localparam int TIMEOUT   = 2000;
   localparam int SAT       = 1048575;

   logic        clk = 1'b0;
   logic        rst;
   logic        pwm_in;
   logic [3:0]  note_code;
   logic        note_valid;
   logic        locked;
   logic [19:0] period;
   logic [19:0] low_width;

   tone_decoder #(
      .CLK_PRE(CLK_PRE), .TOL_SHIFT(TOL_SHIFT), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .pwm_in(pwm_in),
      .note_code(note_code), .note_valid(note_valid), .locked(locked),
      .period(period), .low_width(low_width)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int nv_count = 0;
   int t_now    = 0;

   int freq_tab[14] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988};

   // model state: expected note, activity, run of equal codes, time of last pin fall
   int m_code, m_active, m_have_prev, m_run_code, m_run_len, m_last_fall, m_changes;
   int m_exp_period, m_per_valid;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t_now);
      end
   endtask

   always @(negedge clk) if (!rst && note_valid === 1'b1) nv_count++;

   task automatic tick();
      @(negedge clk);
      t_now++;
   endtask

   function automatic int note_p(input int idx);
      return CLK_PRE / freq_tab[idx];
   endfunction

   function automatic int classify(input int g);
      for (int i = 0; i < 14; i++) begin
         int p, d;
         p = note_p(i);
         d = (g > p) ? g - p : p - g;
         if (g < SAT && d <= p / (1 << TOL_SHIFT)) return i + 1;
      end
      return 0;
   endfunction

   task automatic model_set_code(input int c);
      if (c != m_code) m_changes++;
      m_code = c;
   endtask

   task automatic model_silence();
      if (m_active != 0) begin
         model_set_code(0);
         m_active  = 0;
         m_run_len = 0;
      end
   endtask

   task automatic model_reset();
      m_code = 0; m_active = 0; m_have_prev = 0; m_run_code = 0; m_run_len = 0;
      m_exp_period = 0; m_per_valid = 1; m_last_fall = t_now;
   endtask

   task automatic model_fall();
      int gap, c;
      gap = t_now - m_last_fall;
      if (m_active != 0 && gap > TIMEOUT) model_silence();
      m_per_valid  = m_have_prev;
      m_exp_period = (gap > SAT) ? SAT : gap;
      if (m_active == 0) begin
         m_active  = 1;
         m_run_len = 0;
      end else begin
         c = classify(gap);
         if (c == 0)                                   m_run_len = 0;
         else if (m_run_len > 0 && c == m_run_code)    m_run_len++;
         else begin
            m_run_code = c;
            m_run_len  = 1;
         end
         if (c != 0 && m_run_len >= CONFIRM) model_set_code(c);
      end
      m_have_prev = 1;
      m_last_fall = t_now;
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".code"}, 32'(note_code), m_code);
      check_val({tag, ".locked"}, 32'(locked), (m_code != 0) ? 1 : 0);
      check_val({tag, ".nv_cnt"}, nv_count, m_changes);
      if (m_per_valid != 0) check_val({tag, ".period"}, 32'(period), m_exp_period);
`ifndef TONE_DUTY_MEAS_EN
      check_val({tag, ".low_w"}, 32'(low_width), 0);
`endif
   endtask

   // one pin period: fall now, rise after 'low' cycles, return just before the next fall
   task automatic drive_period(input int per, input int low);
      pwm_in = 1'b0;
      model_fall();
      for (int i = 1; i <= per; i++) begin
         tick();
         if (i == low) pwm_in = 1'b1;
         if (i == 6) check_outputs("per");
`ifdef TONE_DUTY_MEAS_EN
         if (i == low + 5) check_val("low_width", 32'(low_width), low);
`endif
      end
   endtask

   task automatic tone(input int per, input int n);
      for (int j = 0; j < n; j++) drive_period(per, per / 4);
   endtask

   task automatic timeout_check();
      while (t_now < m_last_fall + TIMEOUT + 3) tick();
      check_val("to_hold", 32'(note_code), m_code);
      tick();
      check_val("to_code", 32'(note_code), 0);
      check_val("to_locked", 32'(locked), 0);
      tick();
      check_val("to_nv", 32'(note_valid), (m_code != 0) ? 1 : 0);
      model_silence();
      tick();
      check_val("to_nv_cnt", nv_count, m_changes);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check_val("rst.code", 32'(note_code), 0);
      check_val("rst.valid", 32'(note_valid), 0);
      check_val("rst.locked", 32'(locked), 0);
      check_val("rst.period", 32'(period), 0);
      check_val("rst.low_w", 32'(low_width), 0);
   endtask

   initial begin
      rst    = 1'b1;
      pwm_in = 1'b1;
      m_changes = 0;
      tick();
      tick();
      apply_reset();
      tick();

      // fresh lock on DO (code 8, period 478)
      tone(478, 3);
      check_val("do_lock", 32'(note_code), 8);
      check_val("do_locked", 32'(locked), 1);
      check_val("do_nv", nv_count, 1);
      timeout_check();

      // tolerance edges: 478 +/- 7 matches, one beyond does not
      tone(485, 3);
      check_val("tol_hi", 32'(note_code), 8);
      timeout_check();
      tone(486, 4);
      check_val("tol_hi_out", 32'(note_code), 0);
      timeout_check();
      tone(471, 3);
      check_val("tol_lo", 32'(note_code), 8);
      timeout_check();
      tone(470, 4);
      check_val("tol_lo_out", 32'(note_code), 0);
      timeout_check();

      // MI (379) -> FA (358): one FA period keeps MI, second switches
      tone(379, 3);
      check_val("mi_lock", 32'(note_code), 10);
      tone(358, 2);
      check_val("mi_hold", 32'(note_code), 10);
      tone(358, 1);
      check_val("fa_lock", 32'(note_code), 11);

      // fall landing exactly at the timeout count wins over silence
      drive_period(TIMEOUT, TIMEOUT / 4);
      drive_period(358, 89);
      check_val("fe_wins", 32'(note_code), 11);
      check_val("fe_wins_locked", 32'(locked), 1);
      timeout_check();

      // reset while tracking, then three full DO falls to relock
      tone(478, 2);
      apply_reset();
      tone(478, 2);
      check_val("relock_wait", 32'(note_code), 0);
      tone(478, 1);
      check_val("relock", 32'(note_code), 8);

      // random bursts: jittered notes and arbitrary periods
      for (int b = 0; b < 16; b++) begin
         int k, p, tol, per, n;
         n = int'($urandom_range(1, 4));
         if ($urandom_range(0, 4) == 0) begin
            per = int'($urandom_range(260, 1000));
         end else begin
            k   = int'($urandom_range(0, 13));
            p   = note_p(k);
            tol = p / (1 << TOL_SHIFT);
            per = p + int'($urandom_range(0, 2 * tol)) - tol;
         end
         tone(per, n);
         if (b % 5 == 4) timeout_check();
      end
      timeout_check();
      check_val("final_nv_cnt", nv_count, m_changes);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Measures the period of an incoming buzzer-style PWM (active-low pulses, one pulse per tone period) and decodes it into a 4-bit note code.
- Covers the 14 notes DO_..SI (262-988 Hz) and silence.
- Sits on the receive side of the buzzer interface: loopback checking of the tone generator, or decoding a tone stream from another board.
- Reports a confirmed note only after consecutive matching periods; reports silence after a timeout with no pulses.

Parameters:
CLK_PRE, 50_000_000, system clock frequency in Hz; note periods are CLK_PRE/freq (integer division)
TOL_SHIFT, 6, match tolerance: |period - P_k| <= P_k >> TOL_SHIFT (about ±1.56%)
CONFIRM, 2, consecutive matching periods needed to lock a note (1..7)
TIMEOUT, 500_000, cycles after the last falling edge before silence is declared (10 ms)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
pwm_in  input  1  asynchronous tone input, idle high, low pulse starts each period
note_code  output  4  0 = silence/none; 1..7 = DO_,RE_,MI_,FA_,SO_,LA_,SI_ (262,294,330,349,392,440,494 Hz); 8..14 = DO..SI (523,587,659,698,784,880,988 Hz)
note_valid  output  1  one-cycle pulse whenever note_code changes
locked  output  1  high while note_code holds a confirmed note
period  output  20  last measured period in clk cycles
low_width  output  20  last low-pulse width (see Optional Feature)

Behaviour:
- Reset: one clock; synchronous, active-high (rst). All outputs 0, state SILENT, all counters 0. Reset mid-operation clears everything on the next edge.
- Input conditioning: pwm_in is passed through a 2-flop synchronizer, then a registered edge detector. A falling edge (fe) is recognized 3 cycles after the pin falls.
- Period counter (20 bit):
  - Cleared to 1 on fe.
  - Otherwise increments, saturating at 2^20-1.
  - On fe, the pre-clear value is captured into period.
  - This counter is also the timeout counter.
- Classification: on fe, the captured period is compared against the 14 constants P_k = CLK_PRE/f_k.
  - Result is the lowest matching code; 0 if none matches.
  - Computed in the fe cycle and used for state update in the same cycle.
- States:
  - SILENT: no activity. fe -> ARMED; no period is valid yet.
  - ARMED: waiting for the first full period.
    - fe with match c -> cand=c, mcnt=1; go to TRACK, or straight to lock if CONFIRM==1.
    - fe with no match -> stay in ARMED.
  - TRACK: confirming a candidate.
    - fe with code==cand -> mcnt+1; when mcnt reaches CONFIRM -> LOCKED, with note_code=cand and locked=1.
    - fe with a different nonzero code -> cand=code, mcnt=1.
    - fe with no match -> ARMED.
  - LOCKED:
    - fe with code==note_code -> stay.
    - Otherwise -> TRACK (mismatch) or ARMED (no match), with cand/mcnt restarted. note_code and locked are held until a new lock or silence.
    - A new lock with the same code as held note_code produces no note_valid pulse.
- Timeout: in any state except SILENT, when the counter equals TIMEOUT with no fe in that cycle:
  - go to SILENT;
  - note_code=0, locked=0;
  - mcnt and cand cleared.
  - If fe and the timeout coincide, fe wins.
- note_valid: registered; high for exactly one cycle in the cycle after note_code takes a new value. This applies both to a new lock and to entry into silence from a nonzero code.
- Latency: pin falling edge that completes the CONFIRM-th period -> note_code updated 4 cycles later, with note_valid in the following cycle.
- Widths: P_k constants fit in 18 bits at the default CLK_PRE. The tolerance compare is done in 21-bit signed arithmetic; no wrap-around. A saturated period never matches.

Optional Feature:
- Macro name: TONE_DUTY_MEAS_EN.
- Defined:
  - A 20-bit low-width counter is cleared on fe, increments while the synchronized input is low, and saturates.
  - On the synchronized rising edge its value is captured into low_width.
  - low_width is reset to 0.
- Undefined: the counter is not built and low_width is tied to 0.

Test Plan:
- Square wave, period 95602, low 1493: after the 3rd falling edge -> note_code=8, locked=1, one note_valid pulse; period=95602.
- Periods of 96500 -> locks code 8 (diff 898 < 1493). Periods of 98000 -> never locks (misses DO ±1493 and SI_ ±1581); note_code stays 0.
- Locked on MI (75872), switch to FA (71633): note_code stays 10 for 1 FA period, becomes 11 after the 2nd; exactly one note_valid pulse.
- Pin held high after lock: exactly TIMEOUT=500000 cycles after the last recognized fe -> note_code=0, locked=0, one note_valid pulse.
- rst asserted for 1 cycle in TRACK: next cycle all outputs 0, state SILENT; 3 more DO periods are needed to relock.
- With TONE_DUTY_MEAS_EN, low pulse of 2987 cycles -> low_width=2987 after the rising edge. Without the macro, low_width=0 throughout.
